// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: controller state encoding, instruction width
// and the NOP encoding loaded into IF/ID on a flush.
package cpu_pipe_pkg;

   localparam int unsigned INSTR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// IF/ID stall-control bundle between the hazard/branch logic and the
// pipe_stall_ctrl block. Optional macro: STALL_PERF_CNT_EN adds stall_cnt.
interface pipe_stall_ctrl_if;
   import cpu_pipe_pkg::*;

   logic               hz_stall;
   logic [1:0]         hz_cycles;
   logic               br_flush;
   logic [INSTR_W-1:0] if_instr;
   logic [INSTR_W-1:0] if_pc1;
   logic               pc_en;
   logic [INSTR_W-1:0] id_instr;
   logic [INSTR_W-1:0] id_pc1;
   logic               id_valid;
   logic               ex_bubble;
   logic               busy;
`ifdef STALL_PERF_CNT_EN
   logic [15:0]        stall_cnt;

   modport master (
      output hz_stall, hz_cycles, br_flush, if_instr, if_pc1,
      input  pc_en, id_instr, id_pc1, id_valid, ex_bubble, busy, stall_cnt
   );

   modport slave (
      input  hz_stall, hz_cycles, br_flush, if_instr, if_pc1,
      output pc_en, id_instr, id_pc1, id_valid, ex_bubble, busy, stall_cnt
   );
`else
   modport master (
      output hz_stall, hz_cycles, br_flush, if_instr, if_pc1,
      input  pc_en, id_instr, id_pc1, id_valid, ex_bubble, busy
   );

   modport slave (
      input  hz_stall, hz_cycles, br_flush, if_instr, if_pc1,
      output pc_en, id_instr, id_pc1, id_valid, ex_bubble, busy
   );
`endif

endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: owns the IF/ID register, gates the PC
// and injects ID/EX bubbles for load-use stalls and taken branches.
// Optional macro: STALL_PERF_CNT_EN adds a saturating stall-cycle counter.
module pipe_stall_ctrl
   import cpu_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   pipe_stall_ctrl_if.slave  bus
);

   state_t             state, state_nxt;
   logic [1:0]         cnt, cnt_nxt;
   logic [1:0]         n_req;
   logic               pc_en_c;
   logic               bubble_c;
   logic               load_c;
   logic               flush_c;
   logic [INSTR_W-1:0] id_instr_q;
   logic [INSTR_W-1:0] id_pc1_q;
   logic               id_valid_q;

   // Next-state and combinational pipeline controls; flush outranks stall.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_en_c   = 1'b1;
      bubble_c  = 1'b0;
      load_c    = 1'b0;
      flush_c   = 1'b0;
      n_req     = (bus.hz_cycles == 2'd0) ? 2'd1 : bus.hz_cycles;
      unique case (state)
         RUN: begin
            if (bus.br_flush) begin
               bubble_c  = 1'b1;
               flush_c   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = FLUSH;
            end else if (bus.hz_stall) begin
               pc_en_c   = 1'b0;
               bubble_c  = 1'b1;
               cnt_nxt   = n_req - 2'd1;
               state_nxt = (n_req > 2'd1) ? STALL : RUN;
            end else begin
               load_c    = 1'b1;
            end
         end
         STALL: begin
            if (bus.br_flush) begin
               bubble_c  = 1'b1;
               flush_c   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = FLUSH;
            end else begin
               pc_en_c   = 1'b0;
               bubble_c  = 1'b1;
               // cnt<=1 rather than ==1 so a corrupted 0 can never wrap.
               if (cnt <= 2'd1) begin
                  cnt_nxt   = '0;
                  state_nxt = RUN;
               end else begin
                  cnt_nxt   = cnt - 2'd1;
               end
            end
         end
         FLUSH: begin
            bubble_c  = 1'b1;
            flush_c   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = RUN;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = RUN;
         end
      endcase
      // Outputs are forced to their idle values for the whole reset window.
      if (!rst_n) begin
         pc_en_c  = 1'b1;
         bubble_c = 1'b0;
      end
   end

   // Controller state and remaining-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // IF/ID register: load on free run, NOP on flush, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_instr_q <= NOP_INSTR;
         id_pc1_q   <= '0;
         id_valid_q <= 1'b0;
      end else if (flush_c) begin
         id_instr_q <= NOP_INSTR;
         id_pc1_q   <= '0;
         id_valid_q <= 1'b0;
      end else if (load_c) begin
         id_instr_q <= bus.if_instr;
         id_pc1_q   <= bus.if_pc1;
         id_valid_q <= 1'b1;
      end
   end

`ifdef STALL_PERF_CNT_EN
   logic [15:0] stall_cnt_q;

   // Saturating count of clock edges on which the PC was frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (!pc_en_c && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
`endif

   assign bus.pc_en     = pc_en_c;
   assign bus.ex_bubble = bubble_c;
   assign bus.busy      = (state != RUN);
   assign bus.id_instr  = id_instr_q;
   assign bus.id_pc1    = id_pc1_q;
   assign bus.id_valid  = id_valid_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: per-cycle vector table plus hand-written
// reset-mid-stall and (with STALL_PERF_CNT_EN) performance-counter sequences.
module tb_pipe_stall_ctrl;
   import cpu_pipe_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   pipe_stall_ctrl_if bus ();

   pipe_stall_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hz;
      logic [1:0]  cyc;
      logic        br;
      logic [15:0] instr;
      logic [15:0] pc1;
      logic        e_pc_en;
      logic        e_bub;
      logic        e_busy;
      logic [15:0] e_instr;
      logic [15:0] e_pc1;
      logic        e_valid;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic hz, input logic [1:0] cyc, input logic br,
                      input logic [15:0] instr, input logic [15:0] pc1,
                      input logic e_pc_en, input logic e_bub, input logic e_busy,
                      input logic [15:0] e_instr, input logic [15:0] e_pc1,
                      input logic e_valid);
      vec_t v;
      v.hz = hz; v.cyc = cyc; v.br = br; v.instr = instr; v.pc1 = pc1;
      v.e_pc_en = e_pc_en; v.e_bub = e_bub; v.e_busy = e_busy;
      v.e_instr = e_instr; v.e_pc1 = e_pc1; v.e_valid = e_valid;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic hz, input logic [1:0] cyc, input logic br,
                        input logic [15:0] instr, input logic [15:0] pc1);
      bus.hz_stall  = hz;
      bus.hz_cycles = cyc;
      bus.br_flush  = br;
      bus.if_instr  = instr;
      bus.if_pc1    = pc1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      // Requests asserted during reset must not leak to the outputs.
      drive(1'b1, 2'd3, 1'b1, 16'hFFFF, 16'hFFFF);
      #2;
      check("rst pc_en",     {15'd0, bus.pc_en},     16'd1);
      check("rst ex_bubble", {15'd0, bus.ex_bubble}, 16'd0);
      check("rst busy",      {15'd0, bus.busy},      16'd0);
      check("rst id_instr",  bus.id_instr,           16'h0000);
      check("rst id_pc1",    bus.id_pc1,             16'h0000);
      check("rst id_valid",  {15'd0, bus.id_valid},  16'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 16'h9999, 16'h0099);
      #1;
      check("rel id_instr", bus.id_instr,          16'h0000);
      check("rel id_valid", {15'd0, bus.id_valid}, 16'd0);
      check("rel busy",     {15'd0, bus.busy},     16'd0);

      //   hz   cyc   br   instr     pc1       pc bub busy  id_instr  id_pc1    valid
      add(1'b0, 2'd0, 1'b0, 16'h1234, 16'h0001, 1, 0, 0, 16'h1234, 16'h0001, 1);
      add(1'b0, 2'd0, 1'b0, 16'h5678, 16'h0002, 1, 0, 0, 16'h5678, 16'h0002, 1);
      add(1'b1, 2'd3, 1'b0, 16'hAAAA, 16'h0003, 0, 1, 0, 16'h5678, 16'h0002, 1);
      add(1'b0, 2'd0, 1'b0, 16'hBBBB, 16'h0003, 0, 1, 1, 16'h5678, 16'h0002, 1);
      add(1'b0, 2'd0, 1'b0, 16'hBBBB, 16'h0003, 0, 1, 1, 16'h5678, 16'h0002, 1);
      add(1'b0, 2'd0, 1'b0, 16'hCCCC, 16'h0004, 1, 0, 0, 16'hCCCC, 16'h0004, 1);
      add(1'b1, 2'd0, 1'b0, 16'hDDDD, 16'h0005, 0, 1, 0, 16'hCCCC, 16'h0004, 1);
      add(1'b0, 2'd0, 1'b0, 16'hDDDD, 16'h0005, 1, 0, 0, 16'hDDDD, 16'h0005, 1);
      add(1'b1, 2'd1, 1'b0, 16'hEEEE, 16'h0006, 0, 1, 0, 16'hDDDD, 16'h0005, 1);
      add(1'b1, 2'd2, 1'b0, 16'hEEEE, 16'h0006, 0, 1, 0, 16'hDDDD, 16'h0005, 1);
      add(1'b1, 2'd3, 1'b0, 16'hEEEE, 16'h0006, 0, 1, 1, 16'hDDDD, 16'h0005, 1);
      add(1'b1, 2'd3, 1'b1, 16'h1111, 16'h0007, 1, 1, 0, 16'h0000, 16'h0000, 0);
      add(1'b1, 2'd3, 1'b1, 16'h1111, 16'h0007, 1, 1, 1, 16'h0000, 16'h0000, 0);
      add(1'b0, 2'd0, 1'b0, 16'h2222, 16'h0007, 1, 0, 0, 16'h2222, 16'h0007, 1);
      add(1'b1, 2'd3, 1'b0, 16'h3333, 16'h0008, 0, 1, 0, 16'h2222, 16'h0007, 1);
      add(1'b0, 2'd0, 1'b1, 16'h3333, 16'h0008, 1, 1, 1, 16'h0000, 16'h0000, 0);
      add(1'b0, 2'd0, 1'b0, 16'h3333, 16'h0008, 1, 1, 1, 16'h0000, 16'h0000, 0);
      add(1'b0, 2'd0, 1'b0, 16'h3333, 16'h0008, 1, 0, 0, 16'h3333, 16'h0008, 1);
      add(1'b0, 2'd0, 1'b1, 16'h4444, 16'h0009, 1, 1, 0, 16'h0000, 16'h0000, 0);
      add(1'b1, 2'd3, 1'b0, 16'h4444, 16'h0009, 1, 1, 1, 16'h0000, 16'h0000, 0);
      add(1'b0, 2'd0, 1'b0, 16'h4444, 16'h0009, 1, 0, 0, 16'h4444, 16'h0009, 1);

      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i].hz, vq[i].cyc, vq[i].br, vq[i].instr, vq[i].pc1);
         #1;
         check($sformatf("v%0d pc_en", i),     {15'd0, bus.pc_en},     {15'd0, vq[i].e_pc_en});
         check($sformatf("v%0d ex_bubble", i), {15'd0, bus.ex_bubble}, {15'd0, vq[i].e_bub});
         check($sformatf("v%0d busy", i),      {15'd0, bus.busy},      {15'd0, vq[i].e_busy});
         @(posedge clk);
         #1;
         check($sformatf("v%0d id_instr", i),  bus.id_instr,           vq[i].e_instr);
         check($sformatf("v%0d id_pc1", i),    bus.id_pc1,             vq[i].e_pc1);
         check($sformatf("v%0d id_valid", i),  {15'd0, bus.id_valid},  {15'd0, vq[i].e_valid});
      end

      // Reset asserted mid-STALL while a stall request is still held.
      @(negedge clk);
      drive(1'b1, 2'd3, 1'b0, 16'h7777, 16'h000A);
      @(negedge clk);
      drive(1'b1, 2'd3, 1'b0, 16'h7777, 16'h000A);
      #1;
      check("ms busy before rst", {15'd0, bus.busy}, 16'd1);
      rst_n = 1'b0;
      #1;
      check("ms rst busy",      {15'd0, bus.busy},      16'd0);
      check("ms rst pc_en",     {15'd0, bus.pc_en},     16'd1);
      check("ms rst ex_bubble", {15'd0, bus.ex_bubble}, 16'd0);
      check("ms rst id_valid",  {15'd0, bus.id_valid},  16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 16'h5555, 16'h000B);
      #1;
      check("ms rel pc_en",     {15'd0, bus.pc_en},     16'd1);
      check("ms rel ex_bubble", {15'd0, bus.ex_bubble}, 16'd0);
      check("ms rel id_valid",  {15'd0, bus.id_valid},  16'd0);
      @(posedge clk);
      #1;
      check("ms id_instr", bus.id_instr, 16'h5555);
      @(negedge clk);
      drive(1'b0, 2'd0, 1'b0, 16'h6666, 16'h000C);
      #1;
      check("ms after pc_en",     {15'd0, bus.pc_en},     16'd1);
      check("ms after ex_bubble", {15'd0, bus.ex_bubble}, 16'd0);
      check("ms after busy",      {15'd0, bus.busy},      16'd0);

`ifdef STALL_PERF_CNT_EN
      do_reset();
      #1;
      check("pc reset", bus.stall_cnt, 16'h0000);
      for (int unsigned k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b1, 2'd3, 1'b0, 16'h0000, 16'h0000);
         repeat (3) begin
            @(negedge clk);
            drive(1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
         end
      end
      #1;
      check("pc two stalls", bus.stall_cnt, 16'd6);

      do_reset();
      for (int unsigned k = 0; k < 65534; k++) begin
         drive(1'b1, 2'd1, 1'b0, 16'h0000, 16'h0000);
         @(negedge clk);
      end
      drive(1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      #1;
      check("pc fffe", bus.stall_cnt, 16'hFFFE);
      @(negedge clk);
      drive(1'b1, 2'd3, 1'b0, 16'h0000, 16'h0000);
      repeat (3) begin
         @(negedge clk);
         drive(1'b0, 2'd0, 1'b0, 16'h0000, 16'h0000);
      end
      #1;
      check("pc saturate", bus.stall_cnt, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
